// File: rtl/rv_pkg.sv
// Shared integer-core types: datapath width, register index and the write-back request.
package rv_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int REG_W = $clog2(NREGS);

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        reg_idx_t        rd;
        logic [XLEN-1:0] val;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO of write-back requests that buffers LSU results
// while the ALU holds the register-file write port.
import rv_pkg::*;

module wb_fifo #(
    parameter int DEPTH = 2
) (
    input  logic    clock,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t push_data,
    output logic    full,
    input  logic    pop,
    output logic    empty,
    output wb_req_t head
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_req_t            mem_q   [DEPTH];
    wb_req_t            mem_d   [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push, do_pop;

    // Explicit wrap keeps DEPTH=1 in range.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (do_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/regfile_writeback.sv
// Register-file write-port arbiter (ALU over buffered LSU) with busy scoreboard.
// Optional LSU-deferral counter enabled by defining WB_PERF_EN.
import rv_pkg::*;

module regfile_writeback #(
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            issue_valid,
    input  reg_idx_t        issue_rd,
    input  reg_idx_t        rs1,
    input  reg_idx_t        rs2,
    output logic            hazard,
    input  logic            alu_valid,
    input  reg_idx_t        alu_rd,
    input  logic [XLEN-1:0] alu_val,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  reg_idx_t        lsu_rd,
    input  logic [XLEN-1:0] lsu_val,
    output reg_idx_t        rd,
    output logic [XLEN-1:0] valR,
    output logic            write_en,
    output logic [31:0]     perf_defer
);

    wb_req_t            lsu_req, fifo_head, sel;
    logic               fifo_full, fifo_empty, fifo_pop, sel_vld;
    reg_idx_t           rd_q, rd_d;
    logic [XLEN-1:0]    valr_q, valr_d;
    logic               we_q, we_d;
    logic [NREGS-1:0]   busy_q, busy_d;

    assign lsu_req.rd  = lsu_rd;
    assign lsu_req.val = lsu_val;

    // ready comes from pre-pop occupancy, so a full FIFO never accepts even while draining.
    assign lsu_ready = !fifo_full;
    assign fifo_pop  = !alu_valid && !fifo_empty;

    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (lsu_valid),
        .push_data (lsu_req),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    always_comb begin
        sel_vld = alu_valid || !fifo_empty;
        sel     = fifo_head;
        if (alu_valid) begin
            sel.rd  = alu_rd;
            sel.val = alu_val;
        end
        rd_d   = rd_q;
        valr_d = valr_q;
        we_d   = 1'b0;
        if (sel_vld) begin
            rd_d   = sel.rd;
            valr_d = sel.val;
            we_d   = (sel.rd != '0);
        end
    end

    // Clear lands on the edge reg_file stores the value; a same-cycle issue re-sets it.
    always_comb begin
        busy_d = busy_q;
        if (we_q && rd_q != '0) busy_d[rd_q] = 1'b0;
        if (issue_valid && issue_rd != '0) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_q   <= '0;
            valr_q <= '0;
            we_q   <= 1'b0;
            busy_q <= '0;
        end else begin
            rd_q   <= rd_d;
            valr_q <= valr_d;
            we_q   <= we_d;
            busy_q <= busy_d;
        end
    end

    assign rd       = rd_q;
    assign valR     = valr_q;
    assign write_en = we_q;
    assign hazard   = busy_q[rs1] | busy_q[rs2] | busy_q[issue_rd];

`ifdef WB_PERF_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (!fifo_empty && alu_valid && perf_q != '1) perf_d = perf_q + 32'd1;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) perf_q <= '0;
        else       perf_q <= perf_d;
    end

    assign perf_defer = perf_q;
`else
    assign perf_defer = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback: vector table plus a mid-operation reset sequence.
module tb_regfile_writeback;
    import rv_pkg::*;

    logic            clock = 1'b0;
    logic            reset;
    logic            issue_valid, alu_valid, lsu_valid;
    reg_idx_t        issue_rd, rs1, rs2, alu_rd, lsu_rd;
    logic [XLEN-1:0] alu_val, lsu_val;
    logic            hazard, lsu_ready, write_en;
    reg_idx_t        rd;
    logic [XLEN-1:0] valR;
    logic [31:0]     perf_defer;

    int nvec = 0;
    int nerr = 0;

    always #5 clock = ~clock;

    regfile_writeback dut (
        .clock       (clock),
        .reset       (reset),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .rs1         (rs1),
        .rs2         (rs2),
        .hazard      (hazard),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_val     (alu_val),
        .lsu_valid   (lsu_valid),
        .lsu_ready   (lsu_ready),
        .lsu_rd      (lsu_rd),
        .lsu_val     (lsu_val),
        .rd          (rd),
        .valR        (valR),
        .write_en    (write_en),
        .perf_defer  (perf_defer)
    );

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] aval;
        logic        lv;  logic [4:0] lrd; logic [31:0] lval;
        logic        iv;  logic [4:0] ird;
        logic [4:0]  r1;  logic [4:0] r2;
        logic        haz; logic       rdy;
        logic        we;  logic [4:0] erd; logic [31:0] eval;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        logic av, logic [4:0] ard, logic [31:0] aval,
        logic lv, logic [4:0] lrd, logic [31:0] lval,
        logic iv, logic [4:0] ird, logic [4:0] r1, logic [4:0] r2,
        logic haz, logic rdy, logic we, logic [4:0] erd, logic [31:0] eval);
        vec_t v;
        v.av = av;   v.ard = ard; v.aval = aval;
        v.lv = lv;   v.lrd = lrd; v.lval = lval;
        v.iv = iv;   v.ird = ird; v.r1 = r1; v.r2 = r2;
        v.haz = haz; v.rdy = rdy; v.we = we; v.erd = erd; v.eval = eval;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_val = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_val = 0;
    endtask

    initial begin
        // av ard aval | lv lrd lval | iv ird r1 r2 | haz rdy | we erd eval
        // ALU path
        tbl.push_back(mk(0,0,0,           0,0,0,    1,5,5,0, 0,1, 0,0,0));
        tbl.push_back(mk(1,5,32'hDEADBEEF,0,0,0,    0,0,5,0, 1,1, 1,5,32'hDEADBEEF));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,5,0, 1,1, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,5,0, 0,1, 0,0,0));
        // LSU idle path
        tbl.push_back(mk(0,0,0,           1,4,32'h55,0,0,0,0, 0,1, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,0, 0,1, 1,4,32'h55));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,0, 0,1, 0,0,0));
        // contention; rd=10 offered while full must be refused
        tbl.push_back(mk(0,0,0,           1,7,7,    0,0,0,0, 0,1, 0,0,0));
        tbl.push_back(mk(1,1,32'h11,      1,8,8,    0,0,0,0, 0,1, 1,1,32'h11));
        tbl.push_back(mk(1,2,32'h22,      1,10,10,  0,0,0,0, 0,0, 1,2,32'h22));
        tbl.push_back(mk(1,3,32'h33,      1,10,10,  0,0,0,0, 0,0, 1,3,32'h33));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,0, 0,0, 1,7,7));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,0, 0,1, 1,8,8));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,0, 0,1, 0,0,0));
        // x0
        tbl.push_back(mk(1,0,1,           0,0,0,    1,0,0,0, 0,1, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,0, 0,1, 0,0,0));
        // same-cycle set/clear on rd=9
        tbl.push_back(mk(0,0,0,           0,0,0,    1,9,0,0, 0,1, 0,0,0));
        tbl.push_back(mk(1,9,32'h99,      0,0,0,    0,0,0,9, 1,1, 1,9,32'h99));
        tbl.push_back(mk(0,0,0,           0,0,0,    1,9,0,9, 1,1, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,9, 1,1, 0,0,0));
        tbl.push_back(mk(1,9,32'h98,      0,0,0,    0,0,0,9, 1,1, 1,9,32'h98));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,9, 1,1, 0,0,0));
        tbl.push_back(mk(0,0,0,           0,0,0,    0,0,0,9, 0,1, 0,0,0));

        idle();
        reset = 1;
        #2;
        chk("rst_we", 32'(write_en), 0);
        chk("rst_rd", 32'(rd), 0);
        chk("rst_val", valR, 0);
        chk("rst_rdy", 32'(lsu_ready), 1);
        chk("rst_perf", perf_defer, 0);
        @(posedge clock); @(posedge clock); #1;
        reset = 0;

        foreach (tbl[i]) begin
            alu_valid = tbl[i].av; alu_rd = tbl[i].ard; alu_val = tbl[i].aval;
            lsu_valid = tbl[i].lv; lsu_rd = tbl[i].lrd; lsu_val = tbl[i].lval;
            issue_valid = tbl[i].iv; issue_rd = tbl[i].ird;
            rs1 = tbl[i].r1; rs2 = tbl[i].r2;
            #3;
            chk($sformatf("v%0d_hazard", i), 32'(hazard), 32'(tbl[i].haz));
            chk($sformatf("v%0d_ready", i), 32'(lsu_ready), 32'(tbl[i].rdy));
            @(posedge clock); #1;
            chk($sformatf("v%0d_we", i), 32'(write_en), 32'(tbl[i].we));
            if (tbl[i].we) begin
                chk($sformatf("v%0d_rd", i), 32'(rd), 32'(tbl[i].erd));
                chk($sformatf("v%0d_val", i), valR, tbl[i].eval);
            end
        end

`ifdef WB_PERF_EN
        chk("perf_defer", perf_defer, 3);
`else
        chk("perf_defer", perf_defer, 0);
`endif

        // mid-operation reset with two entries buffered and r6 busy
        idle();
        issue_valid = 1; issue_rd = 6;
        @(posedge clock); #1;
        idle();
        alu_valid = 1; alu_rd = 1; alu_val = 1;
        lsu_valid = 1; lsu_rd = 20; lsu_val = 32'h20;
        @(posedge clock); #1;
        alu_rd = 2; alu_val = 2;
        lsu_rd = 21; lsu_val = 32'h21;
        @(posedge clock); #1;
        idle();
        rs1 = 6;
        #1;
        chk("pre_rst_hazard", 32'(hazard), 1);
        chk("pre_rst_ready", 32'(lsu_ready), 0);
        chk("pre_rst_we", 32'(write_en), 1);
        #1;
        reset = 1;
        #1;
        chk("mid_rst_we", 32'(write_en), 0);
        chk("mid_rst_hazard", 32'(hazard), 0);
        chk("mid_rst_ready", 32'(lsu_ready), 1);
        chk("mid_rst_rd", 32'(rd), 0);
        chk("mid_rst_val", valR, 0);
        chk("mid_rst_perf", perf_defer, 0);
        #2;
        reset = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clock); #1;
            chk($sformatf("post_rst_we%0d", k), 32'(write_en), 0);
            chk($sformatf("post_rst_hazard%0d", k), 32'(hazard), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
